// File: rtl/eeprom_master_if.sv
// Host handshake and I2C pin bundle for eeprom_master.
// The master modport is the initiator side; slave is the host/bus side.
interface eeprom_master_if;
  logic        req;
  logic        we;
  logic [12:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        nack;
  logic        scl;
  logic        sda_o;
  logic        sda_i;

  modport master (
    input  req, we, addr, wdata, sda_i,
    output busy, done, rdata, nack, scl, sda_o
  );

  modport slave (
    output req, we, addr, wdata, sda_i,
    input  busy, done, rdata, nack, scl, sda_o
  );
endinterface

// File: rtl/eeprom_master.sv
// I2C initiator for the 8 KiB serial EEPROM: single-byte random write / random read.
// Every bus primitive is four quarters of Q_CYCLES clocks; SCL/SDA come straight from flops.
module eeprom_master #(
  parameter int         Q_CYCLES = 8,
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic            clk,
  input  logic            reset,
  eeprom_master_if.master bus
);

  localparam int             QW     = (Q_CYCLES > 1) ? $clog2(Q_CYCLES) : 1;
  localparam logic [QW-1:0]  Q_LAST = QW'(Q_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, RSTART, RX_BYTE, MNACK, STOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    quarter, quarter_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [7:0]    tx_byte_n;
  logic          nack_set;

  logic          we_q;
  logic [12:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          sync1, sync2, sampled;
  logic [7:0]    rx_sr, rdata_q;
  logic          nack_q;
  logic          scl_q, sda_q;

  logic accept, q_end, prim_end, sample_pt;

  assign accept    = (state == IDLE) && bus.req;
  assign q_end     = (qcnt == Q_LAST);
  assign prim_end  = q_end && (quarter == 2'd3);
  assign sample_pt = q_end && (quarter == 2'd2);

  // Pin levels for a given primitive/quarter; mid = quarters 1 and 2 (SCL high).
  function automatic logic [1:0] bus_drive(state_t s, logic [1:0] q, logic [3:0] b,
                                           logic [7:0] byte_v);
    logic       mid;
    logic [2:0] sel;
    mid = q[0] ^ q[1];
    sel = 3'd7 - b[2:0];
    case (s)
      START, RSTART:  bus_drive = {mid, ~q[1]};
      TX_BYTE:        bus_drive = {mid, (b == 4'd8) ? 1'b1 : byte_v[sel]};
      RX_BYTE, MNACK: bus_drive = {mid, 1'b1};
      STOP:           bus_drive = {q != 2'd0, q[1]};
      default:        bus_drive = 2'b11;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    nack_set   = 1'b0;
    case (state)
      IDLE: if (bus.req) begin
        state_n    = START;
        bit_idx_n  = '0;
        byte_idx_n = '0;
      end
      START:  if (prim_end) state_n = TX_BYTE;
      TX_BYTE: if (prim_end) begin
        if (bit_idx != 4'd8) begin
          bit_idx_n = bit_idx + 4'd1;
        end else begin
          bit_idx_n = '0;
          if (sampled) begin
            nack_set = 1'b1;
            state_n  = STOP;
          end else if (byte_idx == 2'd3) begin
            state_n = we_q ? STOP : RX_BYTE;
          end else if ((byte_idx == 2'd2) && !we_q) begin
            state_n    = RSTART;
            byte_idx_n = 2'd3;
          end else begin
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      RSTART: if (prim_end) state_n = TX_BYTE;
      RX_BYTE: if (prim_end) begin
        if (bit_idx == 4'd7) begin
          bit_idx_n = '0;
          state_n   = MNACK;
        end else begin
          bit_idx_n = bit_idx + 4'd1;
        end
      end
      MNACK:   if (prim_end) state_n = STOP;
      STOP:    if (prim_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    qcnt_n    = qcnt;
    quarter_n = quarter;
    if ((state == IDLE) || (state == DONE)) begin
      qcnt_n    = '0;
      quarter_n = '0;
    end else if (q_end) begin
      qcnt_n    = '0;
      quarter_n = quarter + 2'd1;
    end else begin
      qcnt_n = qcnt + QW'(1);
    end
  end

  // Byte index 3 is the data byte on a write and the read control byte after RSTART.
  always_comb begin
    case (byte_idx_n)
      2'd0:    tx_byte_n = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte_n = {3'b000, addr_q[12:8]};
      2'd2:    tx_byte_n = addr_q[7:0];
      default: tx_byte_n = we_q ? wdata_q : {DEV_ADDR, 1'b1};
    endcase
  end

  // Pins are registered from next-state values so each edge moves at most one wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      qcnt     <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      state          <= state_n;
      qcnt           <= qcnt_n;
      quarter        <= quarter_n;
      bit_idx        <= bit_idx_n;
      byte_idx       <= byte_idx_n;
      {scl_q, sda_q} <= bus_drive(state_n, quarter_n, bit_idx_n, tx_byte_n);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sampled <= 1'b1;
      rx_sr   <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
    end else begin
      sync1 <= bus.sda_i;
      sync2 <= sync1;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        nack_q  <= 1'b0;
      end else if (nack_set) begin
        nack_q <= 1'b1;
      end
      if (sample_pt) begin
        sampled <= sync2;
        if (state == RX_BYTE) rx_sr <= {rx_sr[6:0], sync2};
      end
      if ((state == STOP) && prim_end && !nack_q && !we_q) rdata_q <= rx_sr;
    end
  end

  assign bus.busy  = (state != IDLE) && (state != DONE);
  assign bus.done  = (state == DONE);
  assign bus.rdata = rdata_q;
  assign bus.nack  = nack_q;
  assign bus.scl   = scl_q;
  assign bus.sda_o = sda_q;

endmodule

// File: tb/tb_eeprom_master.sv
// Bench for eeprom_master: two instances (Q=4, Q=8) share one wire-ANDed bus
// with a behavioural EEPROM; an idle instance holds its pins released.
module tb_eeprom_master;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  eeprom_master_if b4();
  eeprom_master_if b8();

  logic slv_sda = 1'b1;
  logic bus_scl, m_sda, bus_sda;
  assign bus_scl  = b4.scl & b8.scl;
  assign m_sda    = b4.sda_o & b8.sda_o;
  assign bus_sda  = m_sda & slv_sda;
  assign b4.sda_i = bus_sda;
  assign b8.sda_i = bus_sda;

  eeprom_master #(.Q_CYCLES(4), .DEV_ADDR(7'h50)) u_dut4 (.clk(clk), .reset(reset), .bus(b4.master));
  eeprom_master #(.Q_CYCLES(8), .DEV_ADDR(7'h50)) u_dut8 (.clk(clk), .reset(reset), .bus(b8.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM model state and bus observations
  logic [7:0] mem  [8192];
  logic [7:0] refm [8192];
  logic [7:0] rxq [$];
  logic       mack_q [$];
  int         starts, stops, viol;
  bit         present = 1'b1;
  int         nack_at = -1;

  initial begin : eeprom_model
    int pos, nb;
    bit tx, rd, acked;
    logic [7:0] sr, tsr;
    logic [12:0] ptr;
    logic pscl, psda, pmsda, s_scl, s_sda, s_msda;
    pos = 0; nb = 0; tx = 0; rd = 0; acked = 0; sr = '0; tsr = '0; ptr = '0;
    pscl = 1'b1; psda = 1'b1; pmsda = 1'b1;
    forever begin
      @(negedge clk);
      s_scl  = bus_scl;
      s_msda = m_sda;
      s_sda  = s_msda & slv_sda;
      if ((s_scl !== pscl) && (s_msda !== pmsda)) viol++;
      if (s_scl && pscl && (s_sda !== psda)) begin
        if (!s_sda) starts++; else stops++;
        pos = -1; nb = 0; tx = 0;
        slv_sda = 1'b1;
      end else if (s_scl && !pscl) begin
        if ((pos >= 0) && (pos < 8) && !tx) sr = {sr[6:0], s_sda};
        if ((pos == 8) && tx) mack_q.push_back(s_sda);
      end else if (!s_scl && pscl) begin
        pos++;
        if (pos == 8) begin
          if (!tx) begin
            rxq.push_back(sr);
            acked = present && (nb != nack_at);
            if (nb == 0) begin
              acked = acked && (sr[7:1] == 7'h50);
              rd = sr[0];
            end else if (acked && (nb == 1)) ptr[12:8] = sr[4:0];
            else if (acked && (nb == 2)) ptr[7:0] = sr;
            else if (acked) begin
              mem[ptr] = sr;
              ptr++;
            end
            slv_sda = !acked;
            nb++;
          end else begin
            slv_sda = 1'b1;
          end
        end else if (pos == 9) begin
          pos = 0;
          slv_sda = 1'b1;
          if (tx) begin
            tx = 0;
            nb = 9;
          end else if (rd && (nb == 1) && acked) begin
            tx = 1;
            tsr = mem[ptr];
            ptr++;
            slv_sda = tsr[7];
          end
        end else if (tx && (pos >= 1) && (pos <= 7)) begin
          slv_sda = tsr[7-pos];
        end
      end
      pscl = s_scl; psda = s_sda; pmsda = s_msda;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int q, input logic r, input logic w,
                         input logic [12:0] a, input logic [7:0] d);
    if (q == 4) begin
      b4.req = r; b4.we = w; b4.addr = a; b4.wdata = d;
    end else begin
      b8.req = r; b8.we = w; b8.addr = a; b8.wdata = d;
    end
  endtask

  function automatic logic g_busy(input int q);  return (q == 4) ? b4.busy : b8.busy;   endfunction
  function automatic logic g_done(input int q);  return (q == 4) ? b4.done : b8.done;   endfunction
  function automatic logic g_nack(input int q);  return (q == 4) ? b4.nack : b8.nack;   endfunction
  function automatic logic [7:0] g_rdata(input int q); return (q == 4) ? b4.rdata : b8.rdata; endfunction

  // One transaction; checks latency E->done and the busy/done relationship.
  task automatic run(input string tag, input int q, input logic w, input logic [12:0] a,
                     input logic [7:0] d, input int pulse_at, input int exp_lat);
    int e, lat;
    rxq.delete(); mack_q.delete();
    starts = 0; stops = 0; viol = 0;
    @(negedge clk);
    set_req(q, 1'b1, w, a, d);
    e = cyc + 1;
    @(negedge clk);
    set_req(q, 1'b0, ~w, ~a, ~d);
    chk({tag, "_busy_after_accept"}, g_busy(q), 1'b1);
    lat = -1;
    for (int i = 0; i < 260 * q; i++) begin
      if (g_done(q)) begin
        lat = cyc - e;
        break;
      end
      if ((pulse_at > 0) && (i == pulse_at)) set_req(q, 1'b1, w, a ^ 13'h1555, d ^ 8'hFF);
      else if ((pulse_at > 0) && (i == pulse_at + 1)) set_req(q, 1'b0, w, a, d);
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_at_done"}, g_busy(q), 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, "_nbytes"}, rxq.size(), 4);
    chk({tag, "_byte0"}, rxq[0], e0);
    chk({tag, "_byte1"}, rxq[1], e1);
    chk({tag, "_byte2"}, rxq[2], e2);
    chk({tag, "_byte3"}, rxq[3], e3);
  endtask

  initial begin
    logic [12:0] a;
    logic [7:0]  d;
    reset = 1'b1;
    set_req(4, 1'b0, 1'b0, '0, '0);
    set_req(8, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8192; i++) begin
      mem[i]  = 8'(i * 37 + 5);
      refm[i] = 8'(i * 37 + 5);
    end
    repeat (3) @(negedge clk);
    chk("rst_scl", b4.scl, 1'b1);
    chk("rst_sda", b4.sda_o, 1'b1);
    chk("rst_busy", b4.busy, 1'b0);
    chk("rst_done", b4.done, 1'b0);
    chk("rst_rdata", b4.rdata, 8'h00);
    chk("rst_nack", b4.nack, 1'b0);
    reset = 1'b0;

    // write frame, Q=4
    run("wr1234", 4, 1'b1, 13'h1234, 8'h5A, 0, 608);
    refm[13'h1234] = 8'h5A;
    chk("wr1234_nack", b4.nack, 1'b0);
    check_frame("wr1234", 8'hA0, 8'h12, 8'h34, 8'h5A);
    chk("wr1234_starts", starts, 1);
    chk("wr1234_stops", stops, 1);
    chk("wr1234_edge_viol", viol, 0);

    // write then read back at the top address
    run("wr1fff", 4, 1'b1, 13'h1FFF, 8'hA5, 0, 608);
    refm[13'h1FFF] = 8'hA5;
    check_frame("wr1fff", 8'hA0, 8'h1F, 8'hFF, 8'hA5);
    run("rd1fff", 4, 1'b0, 13'h1FFF, 8'h00, 0, 768);
    chk("rd1fff_rdata", b4.rdata, refm[13'h1FFF]);
    chk("rd1fff_nack", b4.nack, 1'b0);
    check_frame("rd1fff", 8'hA0, 8'h1F, 8'hFF, 8'hA1);
    chk("rd1fff_starts", starts, 2);
    chk("rd1fff_stops", stops, 1);
    chk("rd1fff_edge_viol", viol, 0);
    chk("rd1fff_mack_n", mack_q.size(), 1);
    chk("rd1fff_mack", mack_q[0], 1'b1);

    // absent device: control byte not acknowledged
    present = 1'b0;
    run("absent", 4, 1'b0, 13'h0100, 8'h00, 0, 176);
    present = 1'b1;
    chk("absent_nack", b4.nack, 1'b1);
    chk("absent_rdata", b4.rdata, 8'hA5);
    chk("absent_stops", stops, 1);

    // req while busy must not disturb the bytes on the bus
    run("busyreq", 4, 1'b1, 13'h0ABC, 8'h11, 100, 608);
    refm[13'h0ABC] = 8'h11;
    chk("busyreq_nack", b4.nack, 1'b0);
    check_frame("busyreq", 8'hA0, 8'h0A, 8'hBC, 8'h11);

    // NACK at later bytes of a write
    for (int k = 1; k <= 3; k++) begin
      nack_at = k;
      run($sformatf("nack_k%0d", k), 4, 1'b1, 13'h0222, 8'h99, 0, 16 * (2 + 9 * (k + 1)));
      chk($sformatf("nack_k%0d_flag", k), b4.nack, 1'b1);
    end
    nack_at = -1;

    // reset in the middle of the third byte
    @(negedge clk);
    set_req(4, 1'b1, 1'b1, 13'h0444, 8'h77);
    @(negedge clk);
    set_req(4, 1'b0, 1'b0, '0, '0);
    repeat (350) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_scl", b4.scl, 1'b1);
    chk("midrst_sda", b4.sda_o, 1'b1);
    chk("midrst_busy", b4.busy, 1'b0);
    chk("midrst_done", b4.done, 1'b0);
    chk("midrst_rdata", b4.rdata, 8'h00);
    chk("midrst_nack", b4.nack, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run("postrst_wr", 4, 1'b1, 13'h0007, 8'h3C, 0, 608);
    refm[13'h0007] = 8'h3C;
    chk("postrst_nack", b4.nack, 1'b0);
    check_frame("postrst", 8'hA0, 8'h00, 8'h07, 8'h3C);
    run("postrst_rd", 4, 1'b0, 13'h0007, 8'h00, 0, 768);
    chk("postrst_rdata", b4.rdata, refm[13'h0007]);

    // Q=8 random write/read pairs
    for (int n = 0; n < 16; n++) begin
      a = 13'($urandom_range(0, 8191));
      d = 8'($urandom_range(0, 255));
      run($sformatf("q8_wr%0d", n), 8, 1'b1, a, d, 0, 152 * 8);
      refm[a] = d;
      chk($sformatf("q8_wr%0d_nack", n), g_nack(8), 1'b0);
      run($sformatf("q8_rd%0d", n), 8, 1'b0, a, 8'h00, 0, 192 * 8);
      chk($sformatf("q8_rd%0d_rdata", n), g_rdata(8), refm[a]);
      chk($sformatf("q8_rd%0d_nack", n), g_nack(8), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
